// File: rtl/pio_irq_sched_pkg.sv
// pio_irq_sched_pkg: FSM states and PIO register map shared by pio_irq_scheduler
package pio_irq_sched_pkg;
    typedef enum logic [2:0] {INIT, IDLE, RD_REQ, RD_CAP, CLR, PUSH} state_e;
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;
endpackage

// File: rtl/pio_rr_arbiter.sv
// pio_rr_arbiter: picks the first pending request after ptr_i, wrapping modulo NUM_SRC
module pio_rr_arbiter
    import pio_irq_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               valid_o
);
    logic [SRC_W-1:0] idx;
    // Descending scan so the nearest request after ptr_i is written last and wins
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = SRC_W'((int'(ptr_i) + i) % NUM_SRC);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pio_irq_scheduler.sv
// pio_irq_scheduler: round-robin edge-capture service of NUM_SRC PIOs into a timestamped event FIFO.
// Define PIO_IRQ_SCHED_INIT_MASK_EN to write every PIO irq mask to 1 after reset.
module pio_irq_scheduler
    import pio_irq_sched_pkg::*;
#(
    parameter int  NUM_SRC    = 4,
    parameter int  FIFO_DEPTH = 8,
    parameter int  TS_W       = 16,
    localparam int SRC_W      = $clog2(NUM_SRC),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SRC-1:0]     src_irq,
    output logic [NUM_SRC-1:0]     m_chipselect,
    output logic [1:0]             m_address,
    output logic                   m_write_n,
    output logic [31:0]            m_writedata,
    input  logic [32*NUM_SRC-1:0]  m_readdata,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [SRC_W-1:0]       ev_src,
    output logic [TS_W-1:0]        ev_stamp,
    output logic [CNT_W-1:0]       ev_count,
    output logic                   busy
);
    localparam int AW = CNT_W - 1;
    localparam int EW = SRC_W + TS_W;
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
    localparam state_e RST_STATE = INIT;
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e                      state_q, state_d;
    logic [SRC_W-1:0]            grant_q, grant_d, ptr_q, ptr_d, arb_grant;
    logic                        arb_valid;
    logic [TS_W-1:0]             ts_q, stamp_q, stamp_d;
    logic [NUM_SRC-1:0]          cs_q, cs_d;
    logic [1:0]                  addr_q, addr_d;
    logic                        wn_q, wn_d;
    logic [31:0]                 wd_q, wd_d;
    logic [EW-1:0]               mem_q [FIFO_DEPTH];
    logic [AW-1:0]               wr_q, rd_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [NUM_SRC-1:0][31:0]    rdata;
    logic                        push, pop, full, unused_rdata;
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
    logic [SRC_W:0]              idx_q, idx_d;
`endif

    assign rdata        = m_readdata;
    assign unused_rdata = ^m_readdata;
    assign full         = cnt_q == CNT_W'(FIFO_DEPTH);
    assign push         = state_q == PUSH;
    assign pop          = ev_valid && ev_ready;
    assign ev_valid     = cnt_q != '0;
    assign {ev_src, ev_stamp} = mem_q[rd_q];
    assign ev_count     = cnt_q;
    assign busy         = state_q != IDLE;
    assign m_chipselect = cs_q;
    assign m_address    = addr_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = wd_q;

    pio_rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
        .req_i   (src_irq),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // Bus outputs are computed from the next state so they leave the flops aligned with it
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        stamp_d = stamp_q;
        ptr_d   = ptr_q;
        cs_d    = '0;
        addr_d  = PIO_ADDR_DATA;
        wn_d    = 1'b1;
        wd_d    = '0;
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            INIT: begin
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
                if (idx_q == (SRC_W+1)'(NUM_SRC)) begin
                    state_d = IDLE;
                end else begin
                    cs_d   = NUM_SRC'(1) << idx_q;
                    addr_d = PIO_ADDR_MASK;
                    wn_d   = 1'b0;
                    wd_d   = 32'd1;
                    idx_d  = idx_q + (SRC_W+1)'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                if (arb_valid && !full) begin
                    state_d = RD_REQ;
                    grant_d = arb_grant;
                    stamp_d = ts_q;
                end
            end
            RD_REQ:  state_d = RD_CAP;
            RD_CAP:  state_d = rdata[grant_q][0] ? CLR : IDLE;
            CLR:     state_d = PUSH;
            PUSH: begin
                ptr_d   = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RD_REQ || state_d == CLR) begin
            cs_d   = NUM_SRC'(1) << grant_d;
            addr_d = PIO_ADDR_EDGE;
            wn_d   = state_d != CLR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            grant_q <= '0;
            ptr_q   <= SRC_W'(NUM_SRC - 1);
            ts_q    <= '0;
            stamp_q <= '0;
            cs_q    <= '0;
            addr_q  <= '0;
            wn_q    <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            ts_q    <= ts_q + TS_W'(1);
            stamp_q <= stamp_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
        end
    end

`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idx_q <= '0;
        else          idx_q <= idx_d;
    end
`endif

    // Grant is refused when full, so a push never meets a full FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {grant_q, stamp_q};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_pio_irq_scheduler.sv
// tb_pio_irq_scheduler: scoreboard bench with a behavioural edge-capture PIO model per source
module tb_pio_irq_scheduler;
    localparam int NUM_SRC = 4, FIFO_DEPTH = 8, TS_W = 16, SRC_W = 2, CNT_W = 4;
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic                    clk = 1'b0, reset_n = 1'b0;
    logic [NUM_SRC-1:0]      src_irq, m_chipselect, cap, raise, spur;
    logic [1:0]              m_address;
    logic                    m_write_n, ev_valid, ev_ready, busy;
    logic [31:0]             m_writedata;
    logic [32*NUM_SRC-1:0]   m_readdata;
    logic [SRC_W-1:0]        ev_src;
    logic [TS_W-1:0]         ev_stamp;
    logic [CNT_W-1:0]        ev_count;
    logic [SRC_W+TS_W-1:0]   sb [$];
    int                      checks = 0, errors = 0, ts = 0, nrd = 0, nwr = 0, base = 0;

    pio_irq_scheduler #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .src_irq      (src_irq),
        .m_chipselect (m_chipselect),
        .m_address    (m_address),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_src       (ev_src),
        .ev_stamp     (ev_stamp),
        .ev_count     (ev_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign src_irq = cap | spur;

    // Edge-capture PIOs: registered readdata, a clear write beats a new edge in the same cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap        <= '0;
            m_readdata <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_readdata[32*i +: 32] <= {31'b0, m_address == 2'd3 && cap[i]};
                if (m_chipselect[i] && !m_write_n && m_address == 2'd3) cap[i] <= 1'b0;
                else if (raise[i]) cap[i] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int s, input int st);
        sb.push_back({SRC_W'(s), TS_W'(st)});
    endtask

    // Called at a negedge with this cycle's inputs settled; observes, then advances one cycle
    task automatic step();
        logic [SRC_W+TS_W-1:0] e;
        if (m_chipselect != '0 && m_write_n) nrd++;
        if (!m_write_n) nwr++;
        if (ev_valid && ev_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(ev_src), 32'hffff_ffff);
            else begin
                e = sb.pop_front();
                chk("ev_src", 32'(ev_src), 32'(e[SRC_W+TS_W-1:TS_W]));
                chk("ev_stamp", 32'(ev_stamp), 32'(e[TS_W-1:0]));
            end
        end
        @(negedge clk);
        ts++;
    endtask

    task automatic edge_src(input logic [NUM_SRC-1:0] m);
        raise = m;
        step();
        raise = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || src_irq != '0) && n < 50) begin
            step();
            n++;
        end
        if (busy || src_irq != '0) chk("idle_timeout", {27'b0, busy, src_irq}, 0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        raise    = '0;
        spur     = '0;
        ev_ready = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ts      = 0;
`ifdef PIO_IRQ_SCHED_INIT_MASK_EN
        for (int i = 0; i <= NUM_SRC; i++) begin
            if (i > 0) begin
                chk("init_cs", 32'(m_chipselect), 32'(1 << (i - 1)));
                chk("init_addr", 32'(m_address), 2);
                chk("init_wn", 32'(m_write_n), 0);
                chk("init_wd", m_writedata, 1);
            end
            step();
        end
        chk("init_done_busy", 32'(busy), 0);
`endif
    endtask

    initial begin
        raise    = '0;
        spur     = '0;
        ev_ready = 1'b0;
        do_reset();
        chk("rst_cs", 32'(m_chipselect), 0);
        chk("rst_wn", 32'(m_write_n), 1);
        chk("rst_addr", 32'(m_address), 0);
        chk("rst_wd", m_writedata, 0);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_count", 32'(ev_count), 0);
        chk("rst_busy", 32'(busy), 0);

        // single source: read two cycles after the edge lands, clear two cycles later
        expect_ev(2, ts + 1);
        edge_src(4'b0100);
        step();
        chk("rd_cs", 32'(m_chipselect), 32'b0100);
        chk("rd_addr", 32'(m_address), 3);
        chk("rd_wn", 32'(m_write_n), 1);
        step();
        chk("cap_idle", 32'(m_chipselect), 0);
        step();
        chk("clr_cs", 32'(m_chipselect), 32'b0100);
        chk("clr_addr", 32'(m_address), 3);
        chk("clr_wn", 32'(m_write_n), 0);
        chk("clr_wd", m_writedata, 0);
        step();
        chk("push_valid", 32'(ev_valid), 0);
        step();
        chk("ev_valid", 32'(ev_valid), 1);
        chk("ev_count1", 32'(ev_count), 1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("pop_count", 32'(ev_count), 0);

        // round-robin from the reset pointer, then resume after the last grant
        do_reset();
        ev_ready = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) expect_ev(k, ts + 1 + 5 * k);
        edge_src(4'b1111);
        wait_idle();
        expect_ev(0, ts + 1);
        expect_ev(3, ts + 6);
        edge_src(4'b1001);
        wait_idle();
        step();
        chk("rr_drain", 32'(sb.size()), 0);

        // fill the FIFO, hold the ninth edge until one pop makes room
        do_reset();
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            expect_ev(k % NUM_SRC, ts + 1);
            edge_src(NUM_SRC'(1) << (k % NUM_SRC));
            wait_idle();
        end
        chk("full_count", 32'(ev_count), FIFO_DEPTH);
        base = nrd + nwr;
        edge_src(4'b0001);
        repeat (6) step();
        chk("full_busy", 32'(busy), 0);
        chk("full_cs", 32'(m_chipselect), 0);
        chk("full_nobus", 32'(nrd + nwr - base), 0);
        chk("full_irq", 32'(src_irq), 32'b0001);
        expect_ev(0, ts + 1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        repeat (5) step();
        chk("refill_count", 32'(ev_count), FIFO_DEPTH);
        chk("refill_busy", 32'(busy), 0);
        chk("refill_irq", 32'(src_irq), 0);
        ev_ready = 1'b1;
        repeat (FIFO_DEPTH + 1) step();
        chk("drain_count", 32'(ev_count), 0);
        chk("drain_sb", 32'(sb.size()), 0);

        // spurious irq: one read, no clear, no event, pointer stays at source 0
        wait_idle();
        base = nrd;
        nwr  = 0;
        spur = 4'b0010;
        step();
        spur = '0;
        repeat (8) step();
        chk("spur_reads", 32'(nrd - base), 1);
        chk("spur_writes", 32'(nwr), 0);
        chk("spur_count", 32'(ev_count), 0);
        chk("spur_busy", 32'(busy), 0);
        expect_ev(1, ts + 1);
        expect_ev(2, ts + 6);
        edge_src(4'b0110);
        wait_idle();
        step();
        chk("spur_sb", 32'(sb.size()), 0);

        // asynchronous reset during the clear write
        do_reset();
        edge_src(4'b0010);
        repeat (3) step();
        chk("mid_wn_before", 32'(m_write_n), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_cs", 32'(m_chipselect), 0);
        chk("mid_wn", 32'(m_write_n), 1);
        chk("mid_count", 32'(ev_count), 0);
        chk("mid_busy", 32'(busy), 32'(INIT_EN));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
